// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: widths, select encodings and
// the entry record carried through the result stage.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;
  localparam int unsigned ALU_SEL_W = 2;

  typedef enum logic [ALU_SEL_W-1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_D = 2'd3
  } alu_sel_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic [ALU_SEL_W-1:0] sel;
    logic                 zero;
    logic                 neg;
  } alu_entry_t;

endpackage

// File: rtl/alu_flags.sv
// Combinational zero/negative flag derivation for a WIDTH-bit result.
module alu_flags #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  output logic             zero,
  output logic             neg
);

  assign zero = (value == '0);
  assign neg  = value[WIDTH-1];

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage for the ALU result mux: captures result, select tag and
// flags into a two-entry skid buffer with a registered in_ready.
module alu_result_stage
  import alu_pkg::*;
#(
  // WIDTH and SEL_W must match the alu_pkg entry layout.
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned SEL_W = ALU_SEL_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [SEL_W-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] acc_count
);

  alu_entry_t main_q, main_d;
  alu_entry_t skid_q, skid_d;
  alu_entry_t in_entry;
  logic       main_vld_q, main_vld_d;
  logic       skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       in_zero, in_neg;
  logic       in_xfer, out_xfer;

  alu_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .value (in_result),
    .zero  (in_zero),
    .neg   (in_neg)
  );

  always_comb begin
    in_entry        = '0;
    in_entry.result = in_result;
    in_entry.sel    = in_sel;
    in_entry.zero   = in_zero;
    in_entry.neg    = in_neg;
  end

  // in_ready comes straight from the skid valid flop: no path from out_ready.
  assign in_ready = ~skid_vld_q;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;

    if (in_xfer) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (out_xfer) begin
      if (skid_vld_q) begin
        // FULL drains into ONE; in_ready is low so nothing new arrives.
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (in_xfer) begin
        main_d = in_entry;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (main_vld_q) begin
        skid_d     = in_entry;
        skid_vld_d = 1'b1;
      end else begin
        main_d     = in_entry;
        main_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid  = main_vld_q;
  assign out_result = main_q.result;
  assign out_sel    = main_q.sel;
  assign out_zero   = main_q.zero;
  assign out_neg    = main_q.neg;
  assign acc_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_result = '0;
  logic [1:0]  in_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [1:0]  out_sel;
  logic        out_zero;
  logic        out_neg;
  logic [7:0]  acc_count;

  int checks = 0;
  int errors = 0;

  alu_result_stage #(
    .WIDTH (16),
    .SEL_W (2),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .acc_count  (acc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of accepted results, capacity two.
  typedef struct {
    logic [15:0] r;
    logic [1:0]  s;
    logic        z;
    logic        n;
  } exp_t;

  exp_t       q[$];
  exp_t       last;
  logic [7:0] mcount;

  function automatic exp_t mk(input logic [15:0] r, input logic [1:0] s);
    exp_t e;
    e.r = r;
    e.s = s;
    e.z = (r == 16'h0000);
    e.n = (r >= 16'h8000);
    return e;
  endfunction

  initial begin
    q.delete();
    last   = '{r: 16'h0, s: 2'h0, z: 1'b0, n: 1'b0};
    mcount = 8'h00;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        last   = '{r: 16'h0, s: 2'h0, z: 1'b0, n: 1'b0};
        mcount = 8'h00;
      end else begin
        bit ox, ix;
        ox = (q.size() > 0) && out_ready;
        ix = in_valid && (q.size() < 2);
        if (ox) begin
          last = q[0];
          void'(q.pop_front());
        end
        if (ix) begin
          q.push_back(mk(in_result, in_sel));
          mcount = mcount + 8'h01;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_t e;
        e = (q.size() > 0) ? q[0] : last;
        check("m_out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        check("m_in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
        check("m_out_result", {16'b0, out_result}, {16'b0, e.r});
        check("m_out_sel", {30'b0, out_sel}, {30'b0, e.s});
        check("m_out_zero", {31'b0, out_zero}, {31'b0, e.z});
        check("m_out_neg", {31'b0, out_neg}, {31'b0, e.n});
        check("m_acc_count", {24'b0, acc_count}, {24'b0, mcount});
      end
    end
  end

  logic [15:0] vals [4];
  logic        zexp [4];
  logic        nexp [4];

  initial begin
    vals[0] = 16'h0000; vals[1] = 16'h00FF; vals[2] = 16'hFF00; vals[3] = 16'hFFFF;
    zexp[0] = 1'b1; zexp[1] = 1'b0; zexp[2] = 1'b0; zexp[3] = 1'b0;
    nexp[0] = 1'b0; nexp[1] = 1'b0; nexp[2] = 1'b1; nexp[3] = 1'b1;

    // Reset values
    #3;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_result", {16'b0, out_result}, 32'd0);
    check("rst_flags", {30'b0, out_zero, out_neg}, 32'd0);
    check("rst_acc_count", {24'b0, acc_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Stream A..D with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("stream_result", {16'b0, out_result}, {16'b0, vals[i-1]});
        check("stream_zero", {31'b0, out_zero}, {31'b0, zexp[i-1]});
        check("stream_neg", {31'b0, out_neg}, {31'b0, nexp[i-1]});
      end
      in_valid  = 1'b1;
      in_result = vals[i];
      in_sel    = 2'(i);
    end
    @(negedge clk);
    check("stream_result3", {16'b0, out_result}, 32'hFFFF);
    check("stream_sel3", {30'b0, out_sel}, 32'd3);
    check("stream_count", {24'b0, acc_count}, 32'd4);
    in_valid = 1'b0;

    // Back-pressure: fill to FULL, hold a third value that must wait
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_result = 16'h00FF; in_sel = 2'd1;
    @(negedge clk);
    in_result = 16'hFF00; in_sel = 2'd2;
    @(negedge clk);
    check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    check("bp_head", {16'b0, out_result}, 32'h00FF);
    in_result = 16'hFFFF; in_sel = 2'd3;
    @(negedge clk);
    check("bp_not_accepted", {24'b0, acc_count}, 32'd6);
    check("bp_still_full", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_second", {16'b0, out_result}, 32'hFF00);
    check("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    check("bp_third", {16'b0, out_result}, 32'hFFFF);
    check("bp_count", {24'b0, acc_count}, 32'd7);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_empty", {31'b0, out_valid}, 32'd0);
    check("bp_hold_data", {16'b0, out_result}, 32'hFFFF);

    // Simultaneous in/out transfer while in ONE
    out_ready = 1'b0;
    in_valid  = 1'b1; in_result = 16'h1234; in_sel = 2'd1;
    @(negedge clk);
    check("sim_before", {16'b0, out_result}, 32'h1234);
    in_result = 16'h8000; in_sel = 2'd2; out_ready = 1'b1;
    @(negedge clk);
    check("sim_after", {16'b0, out_result}, 32'h8000);
    check("sim_neg", {31'b0, out_neg}, 32'd1);
    check("sim_one", {30'b0, out_valid, in_ready}, 32'd3);
    check("sim_count", {24'b0, acc_count}, 32'd9);

    // Counter wrap over 256 accepted results at full throughput
    for (int i = 0; i < 256; i++) begin
      if (i == 246) check("wrap_ff", {24'b0, acc_count}, 32'hFF);
      if (i == 247) check("wrap_00", {24'b0, acc_count}, 32'h00);
      in_valid  = 1'b1;
      in_result = 16'(i * 257);
      in_sel    = 2'(i);
      @(negedge clk);
    end
    check("wrap_final", {24'b0, acc_count}, 32'd9);
    check("wrap_data", {16'b0, out_result}, 32'hFFFF);

    // Fill to FULL, then assert reset between edges
    out_ready = 1'b0;
    in_result = 16'hABCD; in_sel = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_full", {31'b0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_count", {24'b0, acc_count}, 32'd0);
    check("arst_result", {16'b0, out_result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_result = 16'h00FF; in_sel = 2'd1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_result", {16'b0, out_result}, 32'h00FF);
    check("post_rst_valid", {31'b0, out_valid}, 32'd1);
    check("post_rst_count", {24'b0, acc_count}, 32'd1);
    @(negedge clk);
    check("post_rst_drained", {31'b0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the 16-bit 4-to-1 ALU result mux. It captures the selected result `Z` together with its select tag and derives zero and negative flags. It presents the result to the next consumer through a valid/ready handshake. A 2-entry skid buffer keeps one-result-per-cycle throughput while `in_ready` is driven from a register, with no combinational path from `out_ready`.

## Interface
- `WIDTH`, 16: result width; must match the mux data width.
- `SEL_W`, 2: width of the select tag carried with each result.
- `CNT_W`, 8: width of the accepted-result counter.

- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: a mux result is presented.
- `in_ready` out 1: stage can accept; registered.
- `in_result` in WIDTH: mux output `Z`.
- `in_sel` in SEL_W: mux select `S` that produced `in_result`.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer accepts head entry.
- `out_result` out WIDTH: head result.
- `out_sel` out SEL_W: head select tag.
- `out_zero` out 1: head result == 0.
- `out_neg` out 1: head result bit WIDTH-1.
- `acc_count` out CNT_W: number of results accepted since reset, modulo 2^CNT_W.

## Operation
- Input transfer when `in_valid && in_ready`; output transfer when `out_valid && out_ready`.
- Storage is a main register (drives `out_*`) and a skid register. Each holds {result, sel, zero, neg, valid}.
- Flags are computed from `in_result` at capture and stored; they are never recomputed from registered data.
- Occupancy states:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- Transitions:
  - EMPTY + in-transfer -> ONE.
  - ONE + in-transfer, no out-transfer -> FULL. Incoming data goes to skid.
  - ONE + in-transfer + out-transfer -> ONE. Incoming data loads main.
  - ONE + out-transfer only -> EMPTY.
  - FULL + out-transfer -> ONE. Skid moves to main; `in_ready` is 0 in FULL, so no input is accepted that cycle.
  - All other cases hold state.
- `in_ready` is 0 exactly when the next state is FULL. It is registered, equivalent to !skid.valid.
- Data ordering is strictly FIFO; no result is dropped or duplicated.
- `acc_count` increments by 1 on every in-transfer and wraps from 2^CNT_W-1 to 0.
- When `out_valid` is 0, `out_*` data holds its last value.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_sel`=0, `out_zero`=0, `out_neg`=0, `acc_count`=0, skid invalid.
- Latency: a result accepted at edge N appears on `out_*` with `out_valid`=1 after edge N; it is visible in cycle N+1.
- Throughput: 1 result/cycle while `out_ready` stays 1.
- Back-pressure: if `out_ready` drops while the stage is in ONE, one more result is absorbed (FULL). `in_ready` falls one edge later.
- Release: `out_ready`=1 in FULL drains main. `in_ready` returns to 1 one edge later.
- Simultaneous in- and out-transfer in ONE: the count increments and occupancy is unchanged.
- `rst` asserted mid-operation: all entries are discarded and outputs return to their reset values immediately (asynchronous). The first acceptance is possible on the first edge after `rst` deasserts.
- `in_result`/`in_sel` are ignored whenever `in_ready`=0 or `in_valid`=0.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_WIDTH`=16 and `ALU_SEL_W`=2.
  - Select encodings `SEL_A`=0, `SEL_B`=1, `SEL_C`=2, `SEL_D`=3.
  - Entry typedef {result, sel, zero, neg}.
- One combinational sub-module `alu_flags` computes {zero, neg} from a WIDTH-bit value. The stage instantiates it once, on the input side.
- Occupancy is derived from the two valid bits; no separate state encoding.

## Test plan
- Reset, then stream S=0..3 with A=0x0000, B=0x00FF, C=0xFF00, D=0xFFFF and `out_ready`=1. Required outputs, in order, one cycle after each accept:
  - sel 0: `out_result`=0x0000, zero=1, neg=0.
  - sel 1: 0x00FF, zero=0, neg=0.
  - sel 2: 0xFF00, zero=0, neg=1.
  - sel 3: 0xFFFF, zero=0, neg=1.
  - `acc_count`=4 at the end.
- Back-pressure: `out_ready`=0 while sending 0x00FF then 0xFF00.
  - FULL is reached and `in_ready`=0 on the next cycle.
  - A third value 0xFFFF held on input is not accepted.
  - On `out_ready`=1, outputs are 0x00FF, 0xFF00, 0xFFFF in order with no loss.
- Simultaneous transfer: in ONE, pulse `in_valid` and `out_ready` together. Occupancy stays ONE, main shows the new value next cycle, and the count increments.
- Counter wrap: 256 accepted results produce `acc_count` 0xFF -> 0x00, with no effect on data flow.
- Async reset in FULL: assert `rst` between edges. Required response immediately: `out_valid`=0, `in_ready`=1, `acc_count`=0. After deassertion the next result (0x00FF) is accepted and emerged with no stale data.
